// File: rtl/cfg_write_arbiter.sv
// Two-port write arbiter that owns the PWM/output configuration registers.
// Accepted writes pass through a one-entry commit stage; the registers and debug read reflect committed state only.
module cfg_write_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int ADDR_W     = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   input  logic [ADDR_W-1:0] req_addr0,
   input  logic [ADDR_W-1:0] req_addr1,
   input  logic [7:0]        req_data0,
   input  logic [7:0]        req_data1,
   output logic [1:0]        req_ack,
   input  logic              freeze,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [7:0]        rd_data,
   output logic [7:0]        en_reg_out_7_0,
   output logic [7:0]        en_reg_out_15_8,
   output logic [7:0]        en_reg_pwm_7_0,
   output logic [7:0]        en_reg_pwm_15_8,
   output logic [7:0]        pwm_duty_cycle,
   output logic              wr_strobe,
   output logic              wr_src,
   output logic              bad_addr
);

   localparam logic [ADDR_W-1:0] ADDR_OUT_LO = ADDR_W'(3'd0);
   localparam logic [ADDR_W-1:0] ADDR_OUT_HI = ADDR_W'(3'd1);
   localparam logic [ADDR_W-1:0] ADDR_PWM_LO = ADDR_W'(3'd2);
   localparam logic [ADDR_W-1:0] ADDR_PWM_HI = ADDR_W'(3'd3);
   localparam logic [ADDR_W-1:0] ADDR_DUTY   = ADDR_W'(3'd4);

   logic [1:0]        grant_s;
   logic [ADDR_W-1:0] win_addr_s;
   logic [7:0]        win_data_s;

   logic              last_grant_r;
   logic              stg_valid_r;
   logic [ADDR_W-1:0] stg_addr_r;
   logic [7:0]        stg_data_r;
   logic              stg_src_r;

   logic [7:0]        out_lo_r;
   logic [7:0]        out_hi_r;
   logic [7:0]        pwm_lo_r;
   logic [7:0]        pwm_hi_r;
   logic [7:0]        duty_r;
   logic              wr_strobe_r;
   logic              bad_addr_r;
   logic              wr_src_r;

   function automatic logic addr_mapped(input logic [ADDR_W-1:0] addr);
      logic hit;
      case (addr)
         ADDR_OUT_LO, ADDR_OUT_HI, ADDR_PWM_LO, ADDR_PWM_HI, ADDR_DUTY: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

   // Winner selection; on a tie the round-robin pointer favours the port that did not win last.
   always_comb begin
      grant_s = 2'b00;
      if (rst || freeze) begin
         grant_s = 2'b00;
      end else begin
         case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11: begin
               if (FIXED_PRIO != 0) begin
                  grant_s = 2'b01;
               end else if (last_grant_r) begin
                  grant_s = 2'b01;
               end else begin
                  grant_s = 2'b10;
               end
            end
            default: grant_s = 2'b00;
         endcase
      end
   end

   // Route the winning port's address and data toward the commit stage.
   always_comb begin
      win_addr_s = req_addr0;
      win_data_s = req_data0;
      if (grant_s[1]) begin
         win_addr_s = req_addr1;
         win_data_s = req_data1;
      end else begin
         win_addr_s = req_addr0;
         win_data_s = req_data0;
      end
   end

   assign req_ack = grant_s;

   // One-entry commit stage and round-robin pointer; the stage empties whenever nothing is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         stg_valid_r  <= 1'b0;
         stg_addr_r   <= '0;
         stg_data_r   <= 8'h00;
         stg_src_r    <= 1'b0;
         last_grant_r <= 1'b1;
      end else begin
         stg_valid_r <= |grant_s;
         if (|grant_s) begin
            stg_addr_r   <= win_addr_s;
            stg_data_r   <= win_data_s;
            stg_src_r    <= grant_s[1];
            last_grant_r <= grant_s[1];
         end else begin
            stg_addr_r   <= stg_addr_r;
            stg_data_r   <= stg_data_r;
            stg_src_r    <= stg_src_r;
            last_grant_r <= last_grant_r;
         end
      end
   end

   // Commit the staged write into the register file and pulse the matching status flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_lo_r    <= 8'h00;
         out_hi_r    <= 8'h00;
         pwm_lo_r    <= 8'h00;
         pwm_hi_r    <= 8'h00;
         duty_r      <= 8'h00;
         wr_strobe_r <= 1'b0;
         bad_addr_r  <= 1'b0;
         wr_src_r    <= 1'b0;
      end else begin
         wr_strobe_r <= 1'b0;
         bad_addr_r  <= 1'b0;
         if (stg_valid_r) begin
            wr_src_r    <= stg_src_r;
            wr_strobe_r <= addr_mapped(stg_addr_r);
            bad_addr_r  <= ~addr_mapped(stg_addr_r);
            case (stg_addr_r)
               ADDR_OUT_LO: out_lo_r <= stg_data_r;
               ADDR_OUT_HI: out_hi_r <= stg_data_r;
               ADDR_PWM_LO: pwm_lo_r <= stg_data_r;
               ADDR_PWM_HI: pwm_hi_r <= stg_data_r;
               ADDR_DUTY:   duty_r   <= stg_data_r;
               default:     out_lo_r <= out_lo_r;
            endcase
         end else begin
            wr_src_r <= wr_src_r;
         end
      end
   end

   // Debug read of committed state; unmapped addresses read as zero.
   always_comb begin
      rd_data = 8'h00;
      case (rd_addr)
         ADDR_OUT_LO: rd_data = out_lo_r;
         ADDR_OUT_HI: rd_data = out_hi_r;
         ADDR_PWM_LO: rd_data = pwm_lo_r;
         ADDR_PWM_HI: rd_data = pwm_hi_r;
         ADDR_DUTY:   rd_data = duty_r;
         default:     rd_data = 8'h00;
      endcase
   end

   assign en_reg_out_7_0  = out_lo_r;
   assign en_reg_out_15_8 = out_hi_r;
   assign en_reg_pwm_7_0  = pwm_lo_r;
   assign en_reg_pwm_15_8 = pwm_hi_r;
   assign pwm_duty_cycle  = duty_r;
   assign wr_strobe       = wr_strobe_r;
   assign bad_addr        = bad_addr_r;
   assign wr_src          = wr_src_r;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Bench for cfg_write_arbiter: a round-robin instance (0) and a fixed-priority instance (1) share stimulus
// and are compared against a per-instance register-file reference model.
`timescale 1ns/1ps
module tb_cfg_write_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [6:0] req_addr0 = 7'd0, req_addr1 = 7'd0;
   logic [7:0] req_data0 = 8'h00, req_data1 = 8'h00;
   logic       freeze = 1'b0;
   logic [6:0] rd_addr = 7'd0;

   wire [1:0][1:0]      ack;
   wire [1:0][7:0]      rd;
   wire [1:0][4:0][7:0] dregs;
   wire [1:0]           strobe, bad, src;

   int checks = 0;
   int errors = 0;

   // reference model state, one copy per instance
   logic [7:0] m_regs [2][5];
   int m_last [2];
   int m_pv [2], m_pa [2], m_pd [2], m_ps [2];
   int m_strobe [2], m_bad [2], m_src [2];

   always #5 clk = ~clk;

   cfg_write_arbiter #(.FIXED_PRIO(0), .ADDR_W(7)) dut_rr (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_data0(req_data0), .req_data1(req_data1),
      .req_ack(ack[0]), .freeze(freeze), .rd_addr(rd_addr), .rd_data(rd[0]),
      .en_reg_out_7_0(dregs[0][0]), .en_reg_out_15_8(dregs[0][1]),
      .en_reg_pwm_7_0(dregs[0][2]), .en_reg_pwm_15_8(dregs[0][3]),
      .pwm_duty_cycle(dregs[0][4]),
      .wr_strobe(strobe[0]), .wr_src(src[0]), .bad_addr(bad[0]));

   cfg_write_arbiter #(.FIXED_PRIO(1), .ADDR_W(7)) dut_fx (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_data0(req_data0), .req_data1(req_data1),
      .req_ack(ack[1]), .freeze(freeze), .rd_addr(rd_addr), .rd_data(rd[1]),
      .en_reg_out_7_0(dregs[1][0]), .en_reg_out_15_8(dregs[1][1]),
      .en_reg_pwm_7_0(dregs[1][2]), .en_reg_pwm_15_8(dregs[1][3]),
      .pwm_duty_cycle(dregs[1][4]),
      .wr_strobe(strobe[1]), .wr_src(src[1]), .bad_addr(bad[1]));

   function automatic logic [1:0] model_ack(int d);
      logic [1:0] r;
      r = 2'b00;
      if (rst || freeze)            r = 2'b00;
      else if (req_valid == 2'b01)  r = 2'b01;
      else if (req_valid == 2'b10)  r = 2'b10;
      else if (req_valid == 2'b11) begin
         if (d == 1)                r = 2'b01;
         else                       r = (m_last[d] == 1) ? 2'b01 : 2'b10;
      end
      return r;
   endfunction

   function automatic logic [7:0] model_rd(int d, int a);
      return (a < 5) ? m_regs[d][a] : 8'h00;
   endfunction

   // advance one clock and apply the same edge to both reference models
   task automatic tick();
      logic [1:0] a [2];
      for (int d = 0; d < 2; d++) a[d] = model_ack(d);
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            for (int i = 0; i < 5; i++) m_regs[d][i] = 8'h00;
            m_pv[d] = 0; m_last[d] = 1; m_strobe[d] = 0; m_bad[d] = 0; m_src[d] = 0;
         end else begin
            m_strobe[d] = 0; m_bad[d] = 0;
            if (m_pv[d] == 1) begin
               if (m_pa[d] < 5) begin
                  m_regs[d][m_pa[d]] = m_pd[d][7:0];
                  m_strobe[d] = 1;
               end else begin
                  m_bad[d] = 1;
               end
               m_src[d] = m_ps[d];
            end
            m_pv[d] = (a[d] != 2'b00) ? 1 : 0;
            if (a[d] != 2'b00) begin
               m_ps[d]   = a[d][1] ? 1 : 0;
               m_pa[d]   = a[d][1] ? int'(req_addr1) : int'(req_addr0);
               m_pd[d]   = a[d][1] ? int'(req_data1) : int'(req_data0);
               m_last[d] = m_ps[d];
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; req_valid = 2'b00; freeze = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b11; req_addr0 = 7'd4; req_addr1 = 7'd3;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 2'b00) begin errors++; $display("FAIL reset_ack dut%0d: got %b exp 00", d, ack[d]); end
      end
      tick(); tick();
      rst = 1'b0; req_valid = 2'b00;
      for (int a = 0; a < 6; a++) begin
         rd_addr = 7'(a);
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (rd[d] !== 8'h00) begin errors++; $display("FAIL reset_rd dut%0d a%0d: got %h exp 00", d, a, rd[d]); end
            if (a < 5) begin
               checks++;
               if (dregs[d][a] !== 8'h00) begin errors++; $display("FAIL reset_reg dut%0d r%0d: got %h exp 00", d, a, dregs[d][a]); end
            end
            checks++;
            if ({strobe[d], bad[d], src[d]} !== 3'b000) begin
               errors++; $display("FAIL reset_flags dut%0d: got %b exp 000", d, {strobe[d], bad[d], src[d]});
            end
         end
         tick();
      end
   endtask

   task automatic test_single_write();
      do_reset();
      req_valid = 2'b01; req_addr0 = 7'h04; req_data0 = 8'h80; rd_addr = 7'h04;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 2'b01) begin errors++; $display("FAIL single_ack dut%0d: got %b exp 01", d, ack[d]); end
      end
      tick();
      req_valid = 2'b00;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dregs[d][4] !== 8'h00 || strobe[d] !== 1'b0) begin
            errors++; $display("FAIL single_early dut%0d: got duty %h strobe %b exp 00 0", d, dregs[d][4], strobe[d]);
         end
      end
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dregs[d][4] !== 8'h80 || strobe[d] !== 1'b1 || src[d] !== 1'b0 || rd[d] !== 8'h80) begin
            errors++;
            $display("FAIL single_commit dut%0d: got duty %h strobe %b src %b rd %h exp 80 1 0 80",
                     d, dregs[d][4], strobe[d], src[d], rd[d]);
         end
      end
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (strobe[d] !== 1'b0) begin errors++; $display("FAIL single_pulse dut%0d: got %b exp 0", d, strobe[d]); end
      end
   endtask

   task automatic test_arbitration();
      logic [1:0] rr_seq [4];
      rr_seq[0] = 2'b01; rr_seq[1] = 2'b10; rr_seq[2] = 2'b01; rr_seq[3] = 2'b10;
      do_reset();
      req_valid = 2'b11;
      req_addr0 = 7'h00; req_data0 = 8'h11;
      req_addr1 = 7'h01; req_data1 = 8'h22;
      for (int c = 0; c < 4; c++) begin
         #1;
         checks++;
         if (ack[0] !== rr_seq[c]) begin errors++; $display("FAIL rr_ack c%0d: got %b exp %b", c, ack[0], rr_seq[c]); end
         checks++;
         if (ack[1] !== 2'b01) begin errors++; $display("FAIL fixed_ack c%0d: got %b exp 01", c, ack[1]); end
         tick();
      end
      req_valid = 2'b00;
      tick(); tick();
      #1;
      checks++;
      if (dregs[0][0] !== 8'h11 || dregs[0][1] !== 8'h22) begin
         errors++; $display("FAIL rr_final: got %h %h exp 11 22", dregs[0][0], dregs[0][1]);
      end
      checks++;
      if (dregs[1][0] !== 8'h11 || dregs[1][1] !== 8'h00) begin
         errors++; $display("FAIL fixed_final: got %h %h exp 11 00", dregs[1][0], dregs[1][1]);
      end
   endtask

   task automatic test_bad_addr();
      req_valid = 2'b10; req_addr1 = 7'h05; req_data1 = 8'hFF;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 2'b10) begin errors++; $display("FAIL bad_ack dut%0d: got %b exp 10", d, ack[d]); end
      end
      tick();
      req_valid = 2'b00;
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (bad[d] !== 1'b1 || strobe[d] !== 1'b0 || src[d] !== 1'b1) begin
            errors++; $display("FAIL bad_flags dut%0d: got bad %b strobe %b src %b exp 1 0 1", d, bad[d], strobe[d], src[d]);
         end
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (dregs[d][i] !== m_regs[d][i]) begin
               errors++; $display("FAIL bad_regs dut%0d r%0d: got %h exp %h", d, i, dregs[d][i], m_regs[d][i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      req_valid = 2'b01; req_addr0 = 7'h03; req_data0 = 8'hA1;
      tick();
      req_valid = 2'b10; req_addr1 = 7'h03; req_data1 = 8'hB2;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 2'b10) begin errors++; $display("FAIL b2b_ack dut%0d: got %b exp 10", d, ack[d]); end
      end
      tick();
      req_valid = 2'b00;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dregs[d][3] !== 8'hA1 || src[d] !== 1'b0) begin
            errors++; $display("FAIL b2b_first dut%0d: got %h src %b exp a1 0", d, dregs[d][3], src[d]);
         end
      end
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dregs[d][3] !== 8'hB2 || src[d] !== 1'b1 || strobe[d] !== 1'b1) begin
            errors++; $display("FAIL b2b_last dut%0d: got %h src %b strobe %b exp b2 1 1", d, dregs[d][3], src[d], strobe[d]);
         end
      end
   endtask

   task automatic test_freeze_reset();
      do_reset();
      // a write accepted just before freeze still commits
      req_valid = 2'b01; req_addr0 = 7'h03; req_data0 = 8'h5A;
      tick();
      freeze = 1'b1; req_addr0 = 7'h02; req_data0 = 8'h3C;
      for (int c = 0; c < 3; c++) begin
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (ack[d] !== 2'b00) begin errors++; $display("FAIL freeze_ack c%0d dut%0d: got %b exp 00", c, d, ack[d]); end
         end
         tick();
         if (c == 0) begin
            #1;
            for (int d = 0; d < 2; d++) begin
               checks++;
               if (dregs[d][3] !== 8'h5A || strobe[d] !== 1'b1) begin
                  errors++; $display("FAIL freeze_commit dut%0d: got %h strobe %b exp 5a 1", d, dregs[d][3], strobe[d]);
               end
            end
         end
      end
      freeze = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack[d] !== 2'b01) begin errors++; $display("FAIL unfreeze_ack dut%0d: got %b exp 01", d, ack[d]); end
      end
      tick();
      req_valid = 2'b00; rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      #1;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dregs[d][2] !== 8'h00 || dregs[d][3] !== 8'h00 || strobe[d] !== 1'b0) begin
            errors++; $display("FAIL rst_drop dut%0d: got pwm_lo %h pwm_hi %h strobe %b exp 00 00 0",
                               d, dregs[d][2], dregs[d][3], strobe[d]);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] hold;
      logic [1:0] ea;
      int a;
      hold = 2'b00;
      for (int c = 0; c < 400; c++) begin
         if (!hold[0]) begin
            req_valid[0] = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 7);
            req_addr0 = (a == 7) ? 7'h7F : 7'(a);
            req_data0 = 8'($urandom);
         end
         if (!hold[1]) begin
            req_valid[1] = ($urandom_range(0, 3) != 0);
            a = $urandom_range(0, 7);
            req_addr1 = (a == 7) ? 7'h7F : 7'(a);
            req_data1 = 8'($urandom);
         end
         freeze  = ($urandom_range(0, 9) == 0);
         rst     = ($urandom_range(0, 59) == 0);
         rd_addr = 7'($urandom_range(0, 7));
         #1;
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (ack[d] !== model_ack(d)) begin
               errors++; $display("FAIL rand_ack c%0d dut%0d: got %b exp %b", c, d, ack[d], model_ack(d));
            end
            checks++;
            if (rd[d] !== model_rd(d, int'(rd_addr))) begin
               errors++; $display("FAIL rand_rd c%0d dut%0d: got %h exp %h", c, d, rd[d], model_rd(d, int'(rd_addr)));
            end
            for (int i = 0; i < 5; i++) begin
               checks++;
               if (dregs[d][i] !== m_regs[d][i]) begin
                  errors++; $display("FAIL rand_reg c%0d dut%0d r%0d: got %h exp %h", c, d, i, dregs[d][i], m_regs[d][i]);
               end
            end
            checks++;
            if (strobe[d] !== m_strobe[d][0] || bad[d] !== m_bad[d][0] || src[d] !== m_src[d][0]) begin
               errors++; $display("FAIL rand_flags c%0d dut%0d: got %b%b%b exp %0d%0d%0d",
                                  c, d, strobe[d], bad[d], src[d], m_strobe[d], m_bad[d], m_src[d]);
            end
         end
         ea   = model_ack(0);
         hold = req_valid & ~ea;
         tick();
      end
      rst = 1'b0; freeze = 1'b0; req_valid = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_write();
      test_arbitration();
      test_bad_addr();
      test_back_to_back();
      test_freeze_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cfg_write_arbiter.md
# cfg_write_arbiter

- Owns the five PWM/output configuration registers: en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle.
- Arbitrates register writes from two requesters: port 0 is the SPI-decoded write path and port 1 is the on-chip sequencer (duty ramps and self-test loads).
- Sits between the SPI front end and the PWM/output-enable logic.
- Guarantees one committed write per cycle, deterministic ordering and a single source of truth for register state.

## Interface

Parameters:
- FIXED_PRIO, default 0: 0 selects round-robin between ports; 1 means port 0 always wins ties.
- ADDR_W, default 7: width of the register address.

Ports:
- clk  in  1  system clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  2  per-port write request; bit i belongs to port i.
- req_addr0 / req_addr1  in  ADDR_W  target register address, per port.
- req_data0 / req_data1  in  8  write data, per port.
- req_ack  out  2  combinational; bit i high means port i's request is accepted this cycle.
- freeze  in  1  while high, no request is accepted.
- rd_addr  in  ADDR_W  debug read address.
- rd_data  out  8  combinational read of the committed register; 0 for unmapped addresses.
- en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle  out  8 each  committed register values.
- wr_strobe  out  1  one-cycle pulse when a mapped register is written.
- wr_src  out  1  port that produced the last commit attempt.
- bad_addr  out  1  one-cycle pulse when an accepted write targets an unmapped address.

## Operation

Address map:
- 0x00 = en_reg_out_7_0
- 0x01 = en_reg_out_15_8
- 0x02 = en_reg_pwm_7_0
- 0x03 = en_reg_pwm_15_8
- 0x04 = pwm_duty_cycle
- Every other address is unmapped.

Stage 1, arbitrate:
- A winner is chosen only when freeze=0.
- If exactly one port is valid, that port wins.
- If both ports are valid:
  - FIXED_PRIO=1: port 0 wins.
  - FIXED_PRIO=0: the port opposite to last_grant wins.
- req_ack[winner]=1 in the same cycle. The loser's ack=0, and the loser must hold valid/addr/data stable until acked.
- The winner's addr, data and source are captured into a one-entry commit stage with stg_valid=1.
- last_grant is updated to the winner.
- If no port wins, stg_valid is cleared to 0.

Stage 2, commit:
- Commit happens in the cycle after acceptance, when stg_valid=1.
- Mapped address: the target register is loaded, wr_strobe=1 and wr_src=stg_src.
- Unmapped address: no register changes, bad_addr=1 and wr_src=stg_src.

Pipelining and ordering:
- The stage drains every cycle, so accept and commit overlap. Throughput is one write per cycle.
- Back-to-back writes to the same address commit in acceptance order; the last one wins.
- freeze does not block a commit already in the stage.

Starvation:
- With FIXED_PRIO=1, port 1 can starve indefinitely; this is intended.
- With FIXED_PRIO=0, a continuously-valid port waits at most one cycle.

rd_data:
- Reflects committed state only. It never shows the staged value.

## Timing

Reset (rst=1 at a rising edge):
- All five registers are 0x00.
- stg_valid=0, and any staged write is discarded.
- last_grant=1, so the first tie after reset goes to port 0.
- wr_strobe=0, bad_addr=0, wr_src=0.
- req_ack is 0 while rst=1.

Latency:
- A request acked in cycle N commits at the edge ending cycle N+1.
- The register output shows the new value from cycle N+2.
- wr_strobe/bad_addr are high during cycle N+2 for exactly one cycle.

Edge cases:
- freeze asserted in cycle N: no ack in N. A write acked in N-1 still commits.
- Both ports writing the same address in consecutive cycles: the later ack's data persists.
- rst asserted in the cycle a write sits in the stage: the write is lost and the register stays 0.

## Test plan

- Reset check: after rst, all registers read 0x00 via outputs and rd_data; wr_strobe=0.
- Single write, port 0: addr 0x04, data 0x80 in cycle 1.
  - req_ack=2'b01 in cycle 1.
  - pwm_duty_cycle=0x80 and wr_strobe=1 in cycle 3.
  - wr_src=0.
- Round-robin tie, FIXED_PRIO=0, both ports valid for 4 cycles:
  - port 0 writes addr 0x00 with data 0x11; port 1 writes addr 0x01 with data 0x22.
  - Acks alternate 01, 10, 01, 10.
  - Final values: en_reg_out_7_0=0x11, en_reg_out_15_8=0x22.
- Fixed priority, FIXED_PRIO=1, both ports valid for 3 cycles: port 1's ack stays 0 throughout.
- Unmapped address: port 1 writes addr 0x05, data 0xFF.
  - Acked.
  - bad_addr=1 two cycles later.
  - No register changes; wr_strobe=0.
- Freeze and mid-operation reset:
  - freeze=1 with port 0 valid: no ack until freeze drops.
  - Then ack addr 0x02, data 0x3C, and assert rst in the next cycle: en_reg_pwm_7_0 remains 0x00.
